// File: rtl/alu_pkg.sv
// Op codes, flag indices and sequencer state encoding shared with the 8-bit alu.
// ALU_SEQ_SHIFT_EN adds SHL/SHR/SAR to the ops the sequencer accepts.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBB = 4'd3;
    localparam logic [3:0] OP_INC = 4'd4;
    localparam logic [3:0] OP_DEC = 4'd5;
    localparam logic [3:0] OP_NEG = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_OR  = 4'd8;
    localparam logic [3:0] OP_XOR = 4'd9;
    localparam logic [3:0] OP_NOT = 4'd10;
    localparam logic [3:0] OP_MOV = 4'd11;
    localparam logic [3:0] OP_EXP = 4'd12;
    localparam logic [3:0] OP_SHL = 4'd13;
    localparam logic [3:0] OP_SHR = 4'd14;
    localparam logic [3:0] OP_SAR = 4'd15;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_supported(input logic [3:0] op);
        logic ok;
        ok = op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_INC, OP_DEC,
                        OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV};
`ifdef ALU_SEQ_SHIFT_EN
        ok = ok | (op inside {OP_SHL, OP_SHR, OP_SAR});
`endif
        return ok;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake between the control unit and the alu sequencer.
interface alu_seq_if #(
    parameter int MAX_BYTES = 4
);
    localparam int LEN_W = $clog2(MAX_BYTES) + 1;

    logic                   req_valid;
    logic                   req_ready;
    logic [3:0]             req_op;
    logic [LEN_W-1:0]       req_len;
    logic [8*MAX_BYTES-1:0] req_a;
    logic [8*MAX_BYTES-1:0] req_b;
    logic                   req_carry;
    logic                   res_valid;
    logic                   res_ready;
    logic [8*MAX_BYTES-1:0] res_data;
    logic [3:0]             res_flags;
    logic                   res_err;

    modport master (
        output req_valid, req_op, req_len, req_a, req_b, req_carry, res_ready,
        input  req_ready, res_valid, res_data, res_flags, res_err
    );

    modport slave (
        input  req_valid, req_op, req_len, req_a, req_b, req_carry, res_ready,
        output req_ready, res_valid, res_data, res_flags, res_err
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-byte sequencer driving the shared 8-bit alu one byte per cycle.
// ALU_SEQ_SHIFT_EN enables SHL (LSB-first) and SHR/SAR (MSB-first) chaining.
module alu_seq
    import alu_pkg::*;
#(
    parameter int MAX_BYTES = 4
) (
    input  logic        clock,
    input  logic        reset,
    alu_seq_if.slave    bus,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_op,
    output logic        alu_carry_in,
    output logic        alu_n_oe,
    input  logic [7:0]  alu_result,
    input  logic [3:0]  alu_flags
);
    localparam int LEN_W = $clog2(MAX_BYTES) + 1;
    localparam int IDX_W = $clog2(MAX_BYTES);

    state_t                      state, state_nx;
    logic [3:0]                  op_q;
    logic [LEN_W-1:0]            len_q, cnt_q;
    logic [MAX_BYTES-1:0][7:0]   a_q, b_q, res_q;
    logic                        carry_q, zacc_q, err_q;
    logic [3:0]                  flags_q;

    logic                        accept, bad_req, first, last, msb_first;
    logic [IDX_W-1:0]            idx;
    logic [7:0]                  byte_r;
    logic                        byte_z;

    assign accept  = bus.req_valid && (state == ST_IDLE);
    assign bad_req = (bus.req_len == '0)
                  || (bus.req_len > LEN_W'(MAX_BYTES))
                  || !op_supported(bus.req_op);
    assign first   = (cnt_q == '0);
    assign last    = (cnt_q == len_q - LEN_W'(1));

`ifdef ALU_SEQ_SHIFT_EN
    assign msb_first = (op_q == OP_SHR) || (op_q == OP_SAR);
`else
    assign msb_first = 1'b0;
`endif

    assign idx = msb_first ? IDX_W'(len_q - cnt_q - LEN_W'(1))
                           : IDX_W'(cnt_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = bad_req ? ST_DONE : ST_RUN;
            ST_RUN:  if (last) state_nx = ST_DONE;
            ST_DONE: if (bus.res_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Byte 0 uses the requested op; later bytes continue the carry chain.
    always_comb begin
        alu_a        = '0;
        alu_b        = '0;
        alu_op       = '0;
        alu_carry_in = 1'b0;
        if (state == ST_RUN) begin
            alu_a        = a_q[idx];
            alu_b        = b_q[idx];
            alu_op       = op_q;
            alu_carry_in = carry_q;
            unique case (1'b1)
                op_q == OP_ADD: if (!first) alu_op = OP_ADC;
                op_q == OP_SUB: if (!first) alu_op = OP_SBB;
                op_q == OP_INC: begin
                    alu_b = '0;
                    if (!first) alu_op = OP_ADC;
                end
                op_q == OP_DEC: begin
                    alu_b = '0;
                    if (!first) alu_op = OP_SBB;
                end
                op_q == OP_SAR: if (!first) alu_op = OP_SHR;
                default: ;
            endcase
        end
    end

    assign alu_n_oe = (state != ST_RUN);

    always_comb begin
        byte_r = alu_result;
        byte_z = alu_flags[FLAG_Z];
`ifdef ALU_SEQ_SHIFT_EN
        // The alu shifts in zero; splice in the bit carried out of the previous byte.
        if (!first) begin
            if (op_q == OP_SHL)     byte_r[0] = carry_q;
            else if (msb_first)     byte_r[7] = carry_q;
        end
        if (op_q inside {OP_SHL, OP_SHR, OP_SAR}) byte_z = (byte_r == '0);
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            err_q   <= 1'b0;
            flags_q <= '0;
        end else if (state == ST_IDLE) begin
            if (accept) begin
                op_q    <= bus.req_op;
                len_q   <= bus.req_len;
                a_q     <= bus.req_a;
                b_q     <= bus.req_b;
                carry_q <= bus.req_carry
                        && (bus.req_op == OP_ADC || bus.req_op == OP_SBB);
                cnt_q   <= '0;
                zacc_q  <= 1'b1;
                res_q   <= '0;
                flags_q <= '0;
                err_q   <= bad_req;
            end
        end else if (state == ST_RUN) begin
            res_q[idx] <= byte_r;
            carry_q    <= alu_flags[FLAG_C];
            zacc_q     <= zacc_q & byte_z;
            cnt_q      <= cnt_q + LEN_W'(1);
            if (last) begin
                flags_q[FLAG_Z] <= zacc_q & byte_z;
                flags_q[FLAG_C] <= alu_flags[FLAG_C];
                flags_q[FLAG_N] <= alu_flags[FLAG_N];
                flags_q[FLAG_V] <= alu_flags[FLAG_V];
            end
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.res_valid = (state == ST_DONE);
    assign bus.res_data  = res_q;
    assign bus.res_flags = flags_q;
    assign bus.res_err   = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Table-driven bench for alu_seq with a behavioural 8-bit alu and a result scoreboard.
// ALU_SEQ_SHIFT_EN switches the shift vectors from error to computed results.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int MB = 4;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  len;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] data;
        logic [3:0]  flags;
        logic [3:0]  mask;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  flags;
        logic [3:0]  mask;
        logic        err;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [3:0] alu_op, alu_flags;
    logic       alu_carry_in, alu_n_oe;

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];
    vec_t vecs[$];

    always #5 clock = ~clock;

    alu_seq_if #(.MAX_BYTES(MB)) bus();

    alu_seq #(.MAX_BYTES(MB)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_carry_in (alu_carry_in),
        .alu_n_oe     (alu_n_oe),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags)
    );

    // Returns {V,N,C,Z,result}; C is carry for adds, borrow for subtracts.
    function automatic logic [11:0] alu_model(input logic [3:0] op,
                                              input logic [7:0] a,
                                              input logic [7:0] b,
                                              input logic ci);
        logic [8:0] t;
        logic       v;
        t = '0;
        v = 1'b0;
        case (op)
            OP_ADD: begin
                t = {1'b0, a} + {1'b0, b};
                v = (a[7] == b[7]) && (t[7] != a[7]);
            end
            OP_ADC: begin
                t = {1'b0, a} + {1'b0, b} + {8'b0, ci};
                v = (a[7] == b[7]) && (t[7] != a[7]);
            end
            OP_INC: begin
                t = {1'b0, a} + 9'd1;
                v = (a == 8'h7F);
            end
            OP_SUB: begin
                t = {1'b0, a} - {1'b0, b};
                v = (a[7] != b[7]) && (t[7] != a[7]);
            end
            OP_SBB: begin
                t = {1'b0, a} - {1'b0, b} - {8'b0, ci};
                v = (a[7] != b[7]) && (t[7] != a[7]);
            end
            OP_DEC: begin
                t = {1'b0, a} - 9'd1;
                v = (a == 8'h80);
            end
            OP_AND: t = {1'b0, a & b};
            OP_OR:  t = {1'b0, a | b};
            OP_XOR: t = {1'b0, a ^ b};
            OP_NOT: t = {1'b0, ~a};
            OP_MOV: t = {1'b0, a};
            OP_SHL: t = {a[7], a[6:0], 1'b0};
            OP_SHR: t = {a[0], 1'b0, a[7:1]};
            OP_SAR: t = {a[0], a[7], a[7:1]};
            default: t = '0;
        endcase
        return {v, t[7], t[8], t[7:0] == 8'h00, t[7:0]};
    endfunction

    assign {alu_flags, alu_result} = alu_model(alu_op, alu_a, alu_b, alu_carry_in);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [2:0] len,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic [31:0] d,
                                input logic [3:0] f, input logic [3:0] m,
                                input logic e);
        vec_t v;
        v.op = op; v.len = len; v.a = a; v.b = b; v.cin = cin;
        v.data = d; v.flags = f; v.mask = m; v.err = e;
        return v;
    endfunction

    task automatic run_req(input vec_t v, input int hold);
        int   guard;
        int   edges;
        int   lat;
        exp_t e;
        @(negedge clock);
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_len   = v.len;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        bus.req_carry = v.cin;
        @(posedge clock);
        sb.push_back('{v.data, v.flags, v.mask, v.err});
        #1;
        bus.req_valid = 1'b0;
        check("req_ready_busy", 32'(bus.req_ready), 32'd0);
        check("alu_n_oe_run", 32'(alu_n_oe), 32'(v.err));
        edges = 1;
        while (!bus.res_valid && edges < 20) begin
            @(posedge clock);
            edges++;
            #1;
        end
        lat = v.err ? 1 : int'(v.len) + 1;
        check("latency", 32'(edges), 32'(lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            check("hold_valid", 32'(bus.res_valid), 32'd1);
            check("hold_data", bus.res_data, v.data);
            check("hold_err", 32'(bus.res_err), 32'(v.err));
        end
        @(negedge clock);
        bus.res_ready = 1'b1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("res_data", bus.res_data, e.data);
            check("res_flags", 32'(bus.res_flags & e.mask), 32'(e.flags & e.mask));
            check("res_err", 32'(bus.res_err), 32'(e.err));
        end
        @(posedge clock);
        #1;
        bus.res_ready = 1'b0;
        check("res_valid_drop", 32'(bus.res_valid), 32'd0);
        check("req_ready_back", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_len   = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_carry = 1'b0;
        bus.res_ready = 1'b0;

        vecs.push_back(mk(OP_ADD, 3'd2, 32'h0000_00FF, 32'h1, 1'b0,
                          32'h0000_0100, 4'b0000, 4'hF, 1'b0));
        vecs.push_back(mk(OP_SUB, 3'd4, 32'h0, 32'h1, 1'b0,
                          32'hFFFF_FFFF, 4'b0110, 4'hF, 1'b0));
        vecs.push_back(mk(OP_ADD, 3'd2, 32'h0000_7FFF, 32'h1, 1'b0,
                          32'h0000_8000, 4'b1100, 4'hF, 1'b0));
        vecs.push_back(mk(OP_INC, 3'd2, 32'h0000_FFFF, 32'h55, 1'b0,
                          32'h0000_0000, 4'b0011, 4'hF, 1'b0));
        vecs.push_back(mk(OP_DEC, 3'd3, 32'hAB00_0100, 32'h0, 1'b0,
                          32'h0000_00FF, 4'b0000, 4'hF, 1'b0));
        vecs.push_back(mk(OP_SBB, 3'd2, 32'h0000_1000, 32'h1, 1'b1,
                          32'h0000_0FFE, 4'b0000, 4'hF, 1'b0));
        vecs.push_back(mk(OP_SUB, 3'd2, 32'h0000_8000, 32'h1, 1'b0,
                          32'h0000_7FFF, 4'b1000, 4'hF, 1'b0));
        vecs.push_back(mk(OP_ADD, 3'd4, 32'hFFFF_FFFF, 32'h1, 1'b0,
                          32'h0000_0000, 4'b0011, 4'hF, 1'b0));
        vecs.push_back(mk(OP_AND, 3'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0,
                          32'h00F0_1200, 4'b0000, 4'b0101, 1'b0));
        vecs.push_back(mk(OP_XOR, 3'd2, 32'h0000_1234, 32'h0000_1234, 1'b0,
                          32'h0000_0000, 4'b0001, 4'b0101, 1'b0));
        vecs.push_back(mk(OP_NOT, 3'd1, 32'h0000_000F, 32'hFF, 1'b0,
                          32'h0000_00F0, 4'b0100, 4'b0101, 1'b0));
        vecs.push_back(mk(OP_OR, 3'd3, 32'h0080_0001, 32'h10, 1'b0,
                          32'h0080_0011, 4'b0100, 4'b0101, 1'b0));
        vecs.push_back(mk(OP_MOV, 3'd4, 32'h0, 32'h1234, 1'b0,
                          32'h0, 4'b0001, 4'b0101, 1'b0));
        vecs.push_back(mk(OP_ADD, 3'd0, 32'h12, 32'h34, 1'b0,
                          32'h0, 4'b0000, 4'hF, 1'b1));
        vecs.push_back(mk(OP_NEG, 3'd2, 32'h12, 32'h0, 1'b0,
                          32'h0, 4'b0000, 4'hF, 1'b1));
        vecs.push_back(mk(OP_EXP, 3'd1, 32'h2, 32'h3, 1'b0,
                          32'h0, 4'b0000, 4'hF, 1'b1));
        vecs.push_back(mk(OP_ADD, 3'd5, 32'h1, 32'h1, 1'b0,
                          32'h0, 4'b0000, 4'hF, 1'b1));
`ifdef ALU_SEQ_SHIFT_EN
        vecs.push_back(mk(OP_SAR, 3'd2, 32'h0000_8001, 32'h0, 1'b0,
                          32'h0000_C000, 4'b0010, 4'b0011, 1'b0));
        vecs.push_back(mk(OP_SHL, 3'd2, 32'h0000_0080, 32'h0, 1'b0,
                          32'h0000_0100, 4'b0000, 4'b0011, 1'b0));
`else
        vecs.push_back(mk(OP_SAR, 3'd2, 32'h0000_8001, 32'h0, 1'b0,
                          32'h0, 4'b0000, 4'hF, 1'b1));
        vecs.push_back(mk(OP_SHL, 3'd2, 32'h0000_0080, 32'h0, 1'b0,
                          32'h0, 4'b0000, 4'hF, 1'b1));
`endif

        repeat (2) @(posedge clock);
        #1;
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_res_data", bus.res_data, 32'd0);
        check("rst_res_flags", 32'(bus.res_flags), 32'd0);
        check("rst_res_err", 32'(bus.res_err), 32'd0);
        check("rst_alu_bus", {alu_a, alu_b, 7'd0, alu_carry_in, 4'd0, alu_op}, 32'd0);
        check("rst_alu_n_oe", 32'(alu_n_oe), 32'd1);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) run_req(vecs[i], vecs[i].err ? 5 : (i == 0 ? 2 : 0));

        // Abort a four-byte add in its second RUN cycle.
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_ADD;
        bus.req_len   = 3'd4;
        bus.req_a     = 32'h1111_1111;
        bus.req_b     = 32'h2222_2222;
        bus.req_carry = 1'b0;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        check("abort_running", 32'(alu_n_oe), 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("abort_res_valid", 32'(bus.res_valid), 32'd0);
        check("abort_alu_n_oe", 32'(alu_n_oe), 32'd1);
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_res_data", bus.res_data, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
            check("abort_no_result", 32'(bus.res_valid), 32'd0);
        end

        run_req(mk(OP_ADC, 3'd1, 32'h0000_00FF, 32'h0, 1'b1,
                   32'h0, 4'b0011, 4'hF, 1'b0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
